// File: rtl/control_riesgos_pkg.sv
// Shared pipeline constants for the hazard control unit: FSM encodings,
// counter widths, memory timeout limit and the register-dependence helper.
package control_riesgos_pkg;

    typedef enum logic {
        CORRE  = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    localparam int ANCHO_ESPERA   = 8;
    localparam int ANCHO_CONTADOR = 16;

    localparam logic [ANCHO_ESPERA-1:0] LIMITE_ESPERA = 8'd255;

    // Register zero is hard-wired, so it never creates a dependence.
    function automatic logic depende(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return (r != 5'd0) && ((r == rs) || (r == rt));
    endfunction

endpackage

// File: rtl/control_riesgos_contador_sat.sv
// Saturating up-counter with synchronous clear and count enable.
module contador_sat #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [ANCHO-1:0] cuenta
);

    localparam logic [ANCHO-1:0] UNO   = {{(ANCHO-1){1'b0}}, 1'b1};
    localparam logic [ANCHO-1:0] MAXIMO = {ANCHO{1'b1}};

    // Count register: clear wins over enable, and the count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta <= {ANCHO{1'b0}};
        end else if (clr) begin
            cuenta <= {ANCHO{1'b0}};
        end else if (en && (cuenta != MAXIMO)) begin
            cuenta <= cuenta + UNO;
        end else begin
            cuenta <= cuenta;
        end
    end

endmodule

// File: rtl/control_riesgos.sv
// Pipeline hazard control: load-use / branch bubbles, taken-branch flush,
// full-pipeline freeze on data-memory wait, with statistics and timeout flag.
module control_riesgos
    import control_riesgos_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdEx,
    input  logic [4:0]  RdMem,
    input  logic        EscEx,
    input  logic        LeeMemEx,
    input  logic        EscMem,
    input  logic        LeeMemMem,
    input  logic        SaltoD,
    input  logic        TomadoD,
    input  logic        AccesoMem,
    input  logic        MemListo,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [15:0] ContBurbujas,
    output logic [15:0] ContEspera,
    output logic        ErrorMem
);

    estado_t                   estado_r;
    estado_t                   estadoSig_s;
    logic                      congelar_s;
    logic                      burbuja_s;
    logic                      clrEspera_s;
    logic                      incEspera_s;
    logic [ANCHO_ESPERA-1:0]   cuentaEspera_s;
    logic                      errorMem_r;
    logic                      unused_s;

    // A Memory-stage write that is not a load is already forwarded, so only
    // LeeMemMem matters there; EscMem is carried for interface completeness.
    assign unused_s = EscMem;

    assign congelar_s = AccesoMem && !MemListo;
    assign burbuja_s  = !congelar_s &&
                        ((LeeMemEx && depende(RdEx, RsD, RtD)) ||
                         (SaltoD && EscEx && depende(RdEx, RsD, RtD)) ||
                         (SaltoD && LeeMemMem && depende(RdMem, RsD, RtD)));

    assign clrEspera_s = (estado_r == CORRE);
    assign incEspera_s = (estado_r == ESPERA) && congelar_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r <= CORRE;
        end else begin
            estado_r <= estadoSig_s;
        end
    end

    // Next state plus stall/flush outputs; freeze beats bubble beats flush.
    always_comb begin
        estadoSig_s = estado_r;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;

        case (estado_r)
            CORRE: begin
                if (congelar_s) begin
                    estadoSig_s = ESPERA;
                end else begin
                    estadoSig_s = CORRE;
                end
            end
            ESPERA: begin
                if (!congelar_s) begin
                    estadoSig_s = CORRE;
                end else begin
                    estadoSig_s = ESPERA;
                end
            end
            default: begin
                estadoSig_s = CORRE;
            end
        endcase

        if (congelar_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (burbuja_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (SaltoD && TomadoD) begin
            FlushD = 1'b1;
        end else begin
            FlushD = 1'b0;
        end
    end

    // Sticky timeout: raised on the edge where the wait count hits the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errorMem_r <= 1'b0;
        end else if (incEspera_s && (cuentaEspera_s == (LIMITE_ESPERA - 8'd1))) begin
            errorMem_r <= 1'b1;
        end else begin
            errorMem_r <= errorMem_r;
        end
    end

    assign ErrorMem = errorMem_r;

    contador_sat #(.ANCHO(ANCHO_ESPERA)) u_contEspera (
        .clk    (clk),
        .reset  (reset),
        .clr    (clrEspera_s),
        .en     (incEspera_s),
        .cuenta (cuentaEspera_s)
    );

    contador_sat #(.ANCHO(ANCHO_CONTADOR)) u_contBurbujas (
        .clk    (clk),
        .reset  (reset),
        .clr    (1'b0),
        .en     (burbuja_s),
        .cuenta (ContBurbujas)
    );

    contador_sat #(.ANCHO(ANCHO_CONTADOR)) u_contCongelado (
        .clk    (clk),
        .reset  (reset),
        .clr    (1'b0),
        .en     (congelar_s),
        .cuenta (ContEspera)
    );

endmodule

// File: tb/tb_control_riesgos.sv
// Scoreboard bench for control_riesgos: expected outputs and counters are
// queued when stimulus is applied and compared when the DUT responds.
module tb_control_riesgos;

    logic        clk;
    logic        reset;
    logic [4:0]  RsD, RtD, RdEx, RdMem;
    logic        EscEx, LeeMemEx, EscMem, LeeMemMem;
    logic        SaltoD, TomadoD, AccesoMem, MemListo;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [15:0] ContBurbujas, ContEspera;
    logic        ErrorMem;

    typedef struct {
        string       tag;
        logic [5:0]  vec;
        logic [15:0] bur;
        logic [15:0] esp;
    } esperado_t;

    esperado_t   cola[$];
    int          checks;
    int          errors;
    logic [15:0] expBur;
    logic [15:0] expEsp;

    control_riesgos dut (
        .clk          (clk),
        .reset        (reset),
        .RsD          (RsD),
        .RtD          (RtD),
        .RdEx         (RdEx),
        .RdMem        (RdMem),
        .EscEx        (EscEx),
        .LeeMemEx     (LeeMemEx),
        .EscMem       (EscMem),
        .LeeMemMem    (LeeMemMem),
        .SaltoD       (SaltoD),
        .TomadoD      (TomadoD),
        .AccesoMem    (AccesoMem),
        .MemListo     (MemListo),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ContBurbujas (ContBurbujas),
        .ContEspera   (ContEspera),
        .ErrorMem     (ErrorMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks = checks + 1;
        if (obs !== esp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    function automatic logic usa(input logic [4:0] r);
        return (r != 5'd0) && ((r == RsD) || (r == RtD));
    endfunction

    function automatic logic modeloCong();
        return AccesoMem && !MemListo;
    endfunction

    function automatic logic modeloBurb();
        return !modeloCong() && ((LeeMemEx && usa(RdEx)) ||
                                 (SaltoD && EscEx && usa(RdEx)) ||
                                 (SaltoD && LeeMemMem && usa(RdMem)));
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    function automatic logic [5:0] modeloVec();
        if (modeloCong())             return 6'b111100;
        else if (modeloBurb())        return 6'b110001;
        else if (SaltoD && TomadoD)   return 6'b000010;
        else                          return 6'b000000;
    endfunction

    function automatic logic [31:0] salidas();
        return {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    task automatic limpiar();
        RsD = 5'd0; RtD = 5'd0; RdEx = 5'd0; RdMem = 5'd0;
        EscEx = 1'b0; LeeMemEx = 1'b0; EscMem = 1'b0; LeeMemMem = 1'b0;
        SaltoD = 1'b0; TomadoD = 1'b0; AccesoMem = 1'b0; MemListo = 1'b1;
    endtask

    // Called just after a rising edge with the cycle's inputs already applied.
    task automatic paso(input string tag);
        esperado_t e;
        if (modeloBurb() && (expBur != 16'hFFFF)) expBur = expBur + 16'd1;
        if (modeloCong() && (expEsp != 16'hFFFF)) expEsp = expEsp + 16'd1;
        e.tag = tag;
        e.vec = modeloVec();
        e.bur = expBur;
        e.esp = expEsp;
        cola.push_back(e);
        @(negedge clk);
        e = cola.pop_front();
        comprobar({e.tag, "_stallflush"}, salidas(), {26'd0, e.vec});
        @(posedge clk);
        #1;
        comprobar({e.tag, "_contBurbujas"}, {16'd0, ContBurbujas}, {16'd0, e.bur});
        comprobar({e.tag, "_contEspera"}, {16'd0, ContEspera}, {16'd0, e.esp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expBur = 16'd0;
        expEsp = 16'd0;
        limpiar();
        reset = 1'b1;
        #12;
        comprobar("reset_contBurbujas", {16'd0, ContBurbujas}, 32'd0);
        comprobar("reset_contEspera", {16'd0, ContEspera}, 32'd0);
        comprobar("reset_errorMem", {31'd0, ErrorMem}, 32'd0);
        comprobar("reset_salidas", salidas(), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        paso("reposo");

        // Load-use on Rs.
        LeeMemEx = 1'b1; RdEx = 5'd5; RsD = 5'd5;
        paso("cargaUso");
        limpiar();
        paso("cargaUso_fin");

        // Load followed by a dependent branch: two bubbles, then resolve taken.
        LeeMemEx = 1'b1; RdEx = 5'd7; RtD = 5'd7; SaltoD = 1'b1;
        paso("cargaSalto_1");
        LeeMemEx = 1'b0; RdEx = 5'd0; LeeMemMem = 1'b1; RdMem = 5'd7; EscMem = 1'b1;
        paso("cargaSalto_2");
        LeeMemMem = 1'b0; TomadoD = 1'b1;
        paso("cargaSalto_tomado");
        limpiar();

        // Register zero never creates a bubble.
        EscEx = 1'b1; LeeMemEx = 1'b1; RdEx = 5'd0; RsD = 5'd0; SaltoD = 1'b1;
        LeeMemMem = 1'b1; RdMem = 5'd0;
        paso("registroCero");
        limpiar();

        // ALU result feeding a branch, with taken flag: bubble wins over flush.
        EscEx = 1'b1; RdEx = 5'd12; RsD = 5'd12; SaltoD = 1'b1; TomadoD = 1'b1;
        paso("aluSalto");
        RdEx = 5'd13;
        paso("saltoTomado");
        limpiar();

        // Memory wait on top of a load-use hazard.
        AccesoMem = 1'b1; MemListo = 1'b0; LeeMemEx = 1'b1; RdEx = 5'd5; RsD = 5'd5;
        paso("espera_1");
        comprobar("espera_estado", {31'd0, dut.estado_r}, 32'd1);
        paso("espera_2");
        paso("espera_3");
        MemListo = 1'b1;
        paso("espera_listo");
        comprobar("espera_vuelveCorre", {31'd0, dut.estado_r}, 32'd0);
        limpiar();

        // Timeout: flag must still be clear well before the limit.
        AccesoMem = 1'b1; MemListo = 1'b0;
        for (int i = 0; i < 250; i++) paso("timeout");
        comprobar("timeout_antes", {31'd0, ErrorMem}, 32'd0);
        for (int i = 0; i < 10; i++) paso("timeout");
        comprobar("timeout_error", {31'd0, ErrorMem}, 32'd1);
        MemListo = 1'b1;
        paso("timeout_listo");
        paso("timeout_listo");
        comprobar("timeout_persiste", {31'd0, ErrorMem}, 32'd1);
        limpiar();

        // Asynchronous reset in the middle of a wait.
        AccesoMem = 1'b1; MemListo = 1'b0;
        paso("resetEspera_pre");
        paso("resetEspera_pre");
        #3;
        reset = 1'b1;
        #1;
        comprobar("resetAsinc_estado", {31'd0, dut.estado_r}, 32'd0);
        comprobar("resetAsinc_espera", {24'd0, dut.cuentaEspera_s}, 32'd0);
        comprobar("resetAsinc_contBurbujas", {16'd0, ContBurbujas}, 32'd0);
        comprobar("resetAsinc_contEspera", {16'd0, ContEspera}, 32'd0);
        comprobar("resetAsinc_errorMem", {31'd0, ErrorMem}, 32'd0);
        comprobar("resetAsinc_stalls", salidas(), 32'd60);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expBur = 16'd0;
        expEsp = 16'd0;
        limpiar();
        paso("trasReset");
        LeeMemEx = 1'b1; RdEx = 5'd3; RtD = 5'd3;
        paso("trasReset_burbuja");
        limpiar();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
